// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter sharing one slave port between NUM_MASTERS masters.
// Tracks the owner's burst progress and lock so the grant only moves at legal handover points.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 16,
  localparam int MW            = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic                   hmastlock
);

  localparam int LEN_MAX = (MAX_HOLD > 16) ? MAX_HOLD : 16;
  localparam int RW      = $clog2(LEN_MAX + 1);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } trans_e;

  trans_e                 tr;
  logic [RW-1:0]          len_c;
  logic [RW-1:0]          rem_q, rem_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [MW-1:0]          rr_q, rr_d;
  logic [MW-1:0]          master_q;
  logic                   mastlock_q;
  logic [MW-1:0]          gnt_idx;
  logic [MW-1:0]          cand;
  logic [MW-1:0]          pick_idx;
  logic                   pick_found;
  logic                   ho_raw, ho;

  assign tr = trans_e'(htrans);

  always_comb begin
    unique case (hburst)
      3'b000:         len_c = RW'(1);
      3'b001:         len_c = RW'(MAX_HOLD);
      3'b010, 3'b011: len_c = RW'(4);
      3'b100, 3'b101: len_c = RW'(8);
      default:        len_c = RW'(16);
    endcase
  end

  always_comb begin
    unique case (tr)
      TR_NONSEQ: rem_d = len_c - RW'(1);
      TR_SEQ:    rem_d = (rem_q == '0) ? '0 : rem_q - RW'(1);
      TR_IDLE:   rem_d = '0;
      default:   rem_d = rem_q;
    endcase
  end

  // A locked owner that still asserts its hlock line can never be pre-empted.
  assign ho_raw = (tr == TR_IDLE)
               || (tr == TR_NONSEQ && len_c == RW'(1))
               || (tr == TR_SEQ && rem_q == RW'(1))
               || (rem_q == '0 && tr != TR_BUSY);
  assign ho     = ho_raw && !(mastlock_q && hlock[master_q]);

  // Search starts just past the last pick, so the previous winner is considered last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = MW'(DEFAULT_MASTER);
    cand       = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = MW'((int'(rr_q) + i) % NUM_MASTERS);
      if (!pick_found && hbusreq[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    gnt_d = '0;
    rr_d  = rr_q;
    if (pick_found) begin
      gnt_d[pick_idx] = 1'b1;
      rr_d            = pick_idx;
    end else begin
      gnt_d[DEFAULT_MASTER] = 1'b1;
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_q[i]) gnt_idx = MW'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      gnt_q                 <= '0;
      gnt_q[DEFAULT_MASTER] <= 1'b1;
      rr_q                  <= MW'(DEFAULT_MASTER);
      master_q              <= MW'(DEFAULT_MASTER);
      mastlock_q            <= 1'b0;
      rem_q                 <= '0;
    end else if (hready) begin
      rem_q      <= rem_d;
      master_q   <= gnt_idx;
      mastlock_q <= hlock[gnt_idx];
      if (ho) begin
        gnt_q <= gnt_d;
        rr_q  <= rr_d;
      end
    end
  end

  assign hgrant    = gnt_q;
  assign hmaster   = master_q;
  assign hmastlock = mastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: a cycle model feeds a scoreboard queue,
// and directed checks pin the grant sequences of each scenario.
module tb_ahb_bus_arbiter;

  localparam int N    = 4;
  localparam int DEF  = 0;
  localparam int HOLD = 16;

  logic       hclk = 1'b0;
  logic       hreset;
  logic [3:0] hbusreq, hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;

  always #5 hclk = ~hclk;

  ahb_bus_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF), .MAX_HOLD(HOLD)) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  typedef struct {
    int gnt;
    int mst;
    int lck;
  } exp_t;

  exp_t  sb[$];
  int    n_vec = 0;
  int    n_err = 0;
  string phase = "init";
  int    m_gnt, m_mst, m_lck, m_rr, m_rem;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %0h expected %0h", phase, tag, got, exp);
    end
  endtask

  function automatic int burst_len(input logic [2:0] b);
    case (b)
      3'b000:         return 1;
      3'b001:         return HOLD;
      3'b010, 3'b011: return 4;
      3'b100, 3'b101: return 8;
      default:        return 16;
    endcase
  endfunction

  task automatic model_reset();
    m_gnt = DEF; m_mst = DEF; m_lck = 0; m_rr = DEF; m_rem = 0;
  endtask

  // Advance the model by one edge, queue its prediction, then compare after the edge.
  task automatic cycle();
    exp_t e;
    int   len, old_g, pick, c;
    bit   ho;
    if (hready) begin
      len = burst_len(hburst);
      ho  = (htrans == 2'b00) || (htrans == 2'b10 && len == 1) ||
            (htrans == 2'b11 && m_rem == 1) || (m_rem == 0 && htrans != 2'b01);
      if (m_lck != 0 && hlock[m_mst]) ho = 1'b0;
      old_g = m_gnt;
      if (ho) begin
        pick = -1;
        for (int i = 1; i <= N; i++) begin
          c = (m_rr + i) % N;
          if (pick < 0 && hbusreq[c]) pick = c;
        end
        if (pick >= 0) begin
          m_gnt = pick;
          m_rr  = pick;
        end else begin
          m_gnt = DEF;
        end
      end
      m_mst = old_g;
      m_lck = int'(hlock[old_g]);
      case (htrans)
        2'b10:   m_rem = len - 1;
        2'b11:   m_rem = (m_rem > 0) ? m_rem - 1 : 0;
        2'b00:   m_rem = 0;
        default: m_rem = m_rem;
      endcase
    end
    e = '{m_gnt, m_mst, m_lck};
    sb.push_back(e);
    @(posedge hclk);
    #1;
    e = sb.pop_front();
    check("sb_hgrant", 32'(hgrant), 32'(1) << e.gnt);
    check("sb_hmaster", 32'(hmaster), 32'(e.mst));
    check("sb_hmastlock", 32'(hmastlock), 32'(e.lck));
  endtask

  // Reset is raised between edges; outputs must change without a clock.
  task automatic do_reset();
    hreset = 1'b1;
    #2;
    model_reset();
    check("rst_hgrant", 32'(hgrant), 32'h1);
    check("rst_hmaster", 32'(hmaster), 32'h0);
    check("rst_hmastlock", 32'(hmastlock), 32'h0);
    hreset = 1'b0;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int order[5];
    order = '{1, 2, 3, 0, 1};

    hreset = 1'b1; hbusreq = '0; hlock = '0; htrans = 2'b00; hburst = 3'b000; hready = 1'b1;
    model_reset();

    phase = "reset";
    #12;
    check("hgrant", 32'(hgrant), 32'h1);
    check("hmaster", 32'(hmaster), 32'h0);
    check("hmastlock", 32'(hmastlock), 32'h0);
    hreset = 1'b0;
    repeat (5) begin
      cycle();
      check("hold_hgrant", 32'(hgrant), 32'h1);
    end

    phase = "m2_alone";
    hbusreq = 4'b0100;
    cycle();
    check("hgrant_t1", 32'(hgrant), 32'h4);
    check("hmaster_t1", 32'(hmaster), 32'h0);
    cycle();
    check("hmaster_t2", 32'(hmaster), 32'h2);
    hbusreq = 4'b0000;
    cycle();
    check("park_hgrant", 32'(hgrant), 32'h1);
    cycle();

    phase = "incr4";
    hbusreq = 4'b0010;
    cycle();
    check("hgrant_m1", 32'(hgrant), 32'h2);
    cycle();
    check("hmaster_m1", 32'(hmaster), 32'h1);
    htrans = 2'b10; hburst = 3'b011;
    cycle();
    check("nonseq_hgrant", 32'(hgrant), 32'h2);
    htrans = 2'b11; hbusreq = 4'b1010;
    cycle();
    check("seq1_hgrant", 32'(hgrant), 32'h2);
    cycle();
    check("seq2_hgrant", 32'(hgrant), 32'h2);
    cycle();
    check("seq3_hgrant", 32'(hgrant), 32'h8);
    check("seq3_hmaster", 32'(hmaster), 32'h1);
    htrans = 2'b00; hbusreq = 4'b1000;
    cycle();
    check("hmaster_m3", 32'(hmaster), 32'h3);

    phase = "rr_single";
    do_reset();
    hbusreq = 4'b1111; htrans = 2'b10; hburst = 3'b000;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check($sformatf("order%0d", k), 32'(hgrant), 32'(1) << order[k]);
      if (k == 1) begin
        hready = 1'b0;
        repeat (3) begin
          cycle();
          check("stall_hgrant", 32'(hgrant), 32'h4);
          check("stall_hmaster", 32'(hmaster), 32'h1);
        end
        hready = 1'b1;
      end
    end

    phase = "lock";
    do_reset();
    hbusreq = 4'b0010; hlock = 4'b0010; htrans = 2'b00; hburst = 3'b000;
    cycle();
    check("hgrant_m1", 32'(hgrant), 32'h2);
    cycle();
    check("hmaster_m1", 32'(hmaster), 32'h1);
    check("hmastlock_on", 32'(hmastlock), 32'h1);
    hbusreq = 4'b0110; htrans = 2'b10; hburst = 3'b001;
    for (int k = 0; k < 20; k++) begin
      cycle();
      check("locked_hgrant", 32'(hgrant), 32'h2);
      check("locked_hmastlock", 32'(hmastlock), 32'h1);
      htrans = 2'b11;
    end
    hlock = 4'b0000;
    cycle();
    check("unlock_hgrant", 32'(hgrant), 32'h4);
    htrans = 2'b00; hbusreq = 4'b0100;
    cycle();
    check("hmaster_m2", 32'(hmaster), 32'h2);

    phase = "incr8_reset";
    htrans = 2'b10; hburst = 3'b100;
    cycle();
    htrans = 2'b11;
    repeat (4) begin
      cycle();
      check("burst_hgrant", 32'(hgrant), 32'h4);
    end
    do_reset();
    hbusreq = 4'b0001; htrans = 2'b10; hburst = 3'b100;
    cycle();
    check("restart_hgrant", 32'(hgrant), 32'h1);
    htrans = 2'b11; hbusreq = 4'b0011;
    for (int k = 1; k <= 7; k++) begin
      cycle();
      check($sformatf("seq%0d_hgrant", k), 32'(hgrant), (k < 7) ? 32'h1 : 32'h2);
    end
    htrans = 2'b00; hbusreq = 4'b0000;
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
